// File: rtl/instr_fetch.sv
// Instruction fetch and issue sequencer: fetches 16-bit words over a req/valid
// handshake, runs JMP/NOP/HLT locally and issues all other opcodes downstream.
module instr_fetch #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [3:0]        opcode,
    output logic [3:0]        dst,
    output logic [3:0]        src_a,
    output logic [3:0]        src_b,
    output logic [7:0]        imm,
    output logic              instr_valid,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       issue_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       issue_cnt_q, issue_cnt_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q, halted_d;

    // Widen before slicing so the 8-bit target zero-extends or truncates for any ADDR_W.
    logic [ADDR_W+7:0] jmp_wide;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [3:0]        fetch_op;

    always_comb begin
        jmp_wide = {{ADDR_W{1'b0}}, imem_rdata[7:0]};
        jmp_tgt  = jmp_wide[ADDR_W-1:0];
        fetch_op = imem_rdata[15:12];
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        issue_cnt_d = issue_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_valid) begin
                    ir_d = imem_rdata;
                    pc_d = pc_q + ADDR_W'(1);
                    case (fetch_op)
                        OP_HLT: state_d = S_HALT;
                        OP_JMP: begin
                            pc_d    = jmp_tgt;
                            state_d = run ? S_REQ : S_IDLE;
                        end
                        OP_NOP: state_d = run ? S_REQ : S_IDLE;
                        default: state_d = S_ISSUE;
                    endcase
                end
            end
            S_ISSUE: begin
                if (exec_done) begin
                    issue_cnt_d = issue_cnt_q + 16'd1;
                    state_d     = run ? S_REQ : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so no input reaches an output.
        imem_req_d    = (state_d == S_REQ);
        instr_valid_d = (state_d == S_ISSUE);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            issue_cnt_q   <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            issue_cnt_q   <= issue_cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    always_comb begin
        imem_req    = imem_req_q;
        imem_addr   = pc_q;
        pc          = pc_q;
        instr_valid = instr_valid_q;
        halted      = halted_q;
        issue_cnt   = issue_cnt_q;
        opcode      = ir_q[15:12];
        dst         = ir_q[11:8];
        src_a       = ir_q[7:4];
        src_b       = ir_q[3:0];
        imm         = ir_q[7:0];
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and issue sequencer for the 4-bit-opcode CPU. It holds the program counter and fetches 16-bit instruction words from instruction memory over a request/valid handshake. It latches each word in an instruction register and presents its decoded fields to the control unit and the execute path downstream, holding them until execution signals completion. It executes JMP, NOP and HLT locally; the control unit never sees them.

## Interface
- `ADDR_W`, 8, instruction-memory address width; PC width.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `run`  input  1  fetch enable, sampled only at instruction boundaries (IDLE, or ISSUE with `exec_done`).
- `imem_req`  output  1  fetch request; high in state REQ only.
- `imem_addr`  output  ADDR_W  fetch address; equals `pc`.
- `imem_rdata`  input  16  instruction word; sampled only when `imem_valid`=1 in REQ.
- `imem_valid`  input  1  memory response strobe; ignored outside REQ.
- `opcode`  output  4  `ir[15:12]`, to control unit.
- `dst`  output  4  `ir[11:8]`.
- `src_a`  output  4  `ir[7:4]`.
- `src_b`  output  4  `ir[3:0]`.
- `imm`  output  8  `ir[7:0]`; used by MVI, LDA and JMP.
- `instr_valid`  output  1  high in ISSUE; qualifies the field outputs.
- `exec_done`  input  1  execute path finished the issued instruction; meaningful only in ISSUE.
- `pc`  output  ADDR_W  program counter.
- `halted`  output  1  high in HALT.
- `issue_cnt`  output  16  count of instructions retired through ISSUE; wraps at 16'hFFFF to 0.

## Operation
- States: IDLE, REQ, ISSUE, HALT.
- Reset values: state IDLE; `pc`=0; `ir`=0, so all field outputs are 0; `issue_cnt`=0; `imem_req`, `instr_valid` and `halted` are 0.
- IDLE to REQ when `run`=1. Otherwise the block stays in IDLE.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_valid`=1.
  - On `imem_valid`, `ir` is loaded with `imem_rdata`.
  - On `imem_valid`, `pc` is loaded with `pc+1` modulo 2^ADDR_W, so the maximum address wraps to 0.
- The next state after `imem_valid` in REQ is chosen from `imem_rdata[15:12]`:
  - 4'b1111 HLT: go to HALT; `pc` still increments.
  - 4'b1110 JMP: `pc` is loaded with `imem_rdata[7:0]`, zero-extended or truncated to ADDR_W; this overrides the increment. Go to REQ, or to IDLE if `run`=0.
  - 4'b0000 NOP: go to REQ, or to IDLE if `run`=0.
  - 4'b0001–4'b1101: go to ISSUE.
- ISSUE:
  - `instr_valid`=1; the field outputs stay stable.
  - On `exec_done`=1: `issue_cnt` is incremented; go to REQ if `run`=1, else to IDLE.
- HALT: `halted`=1. Only reset leaves HALT; `run` is ignored.
- `run` falling while in REQ or ISSUE does not abort the instruction. The handshake in progress completes, then the block enters IDLE at the boundary.
- `exec_done` is ignored outside ISSUE. `imem_valid` is ignored outside REQ.

## Timing
- All state, `pc`, `ir` and `issue_cnt` are registers. Outputs decode from state and registers only; there is no combinational path from any input to any output.
- `run` sampled high in IDLE at edge N gives `imem_req`=1 during cycle N+1.
- `imem_valid` at edge M gives `instr_valid`=1 and the new fields during cycle M+1.
- `exec_done` in the first ISSUE cycle is legal. With zero-wait memory, the next `imem_req` is high in the following cycle, so the minimum period is 2 cycles per issued instruction.
- NOP and JMP each cost exactly one REQ cycle with zero-wait memory. There is no ISSUE cycle, and `instr_valid` never pulses for them.
- Asynchronous reset during any state forces all outputs to their reset values immediately, without a clock edge. Any outstanding memory response is lost; the memory must tolerate a dropped `imem_req`. Fetch restarts at `pc`=0 once `rst_n` is high and `run`=1.

## Test plan
- Reset, `run`=1, memory word 0x2312 at address 0, 0-wait, `exec_done` asserted one cycle after `instr_valid` -> `imem_addr`=0. Then `instr_valid` with `opcode`=2, `dst`=3, `src_a`=1, `src_b`=2. Then `pc`=1 and `issue_cnt`=1.
- Word 0xE005 at address 0 -> no `instr_valid` pulse; next `imem_addr`=5. Word 0x0000 at address 5 -> next `imem_addr`=6.
- Word 0xF000 at address 6 -> `halted`=1 and `pc`=7. With `run` held at 1 for 20 cycles, `imem_req` stays 0.
- Memory with 3 wait cycles -> `imem_req` and `imem_addr` are stable for 4 cycles. Toggling `imem_rdata` before `imem_valid` leaves `ir` unchanged.
- ADDR_W=4 and `pc`=15 with an ADD word -> `pc` wraps to 0. `run` dropped during ISSUE -> `exec_done` returns the block to IDLE, and `imem_req` stays 0.
- `rst_n` pulsed low mid-REQ and then mid-ISSUE -> `imem_req`, `instr_valid`, `pc` and `issue_cnt` go to 0 without a clock edge. The following fetch is at address 0.
